// File: rtl/instr_decode_stage_if.sv
// Instruction decode stage bus: the upstream instruction handshake and the
// downstream decoded-instruction handshake, grouped for port hookup.
interface instr_decode_stage_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_instr;
  logic          out_valid;
  logic          out_ready;
  logic          out_type;
  logic [DW-1:0] out_value;
  logic          out_a;
  logic [5:0]    out_comp;
  logic [2:0]    out_dest;
  logic [2:0]    out_jump;
  logic          out_illegal;

  // Producer/consumer side: feeds instructions, consumes decoded results.
  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_type, out_value,
           out_a, out_comp, out_dest, out_jump, out_illegal
  );

  // Decode stage side.
  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_type, out_value,
           out_a, out_comp, out_dest, out_jump, out_illegal
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: decodes A/C instruction words into fields, buffers
// them in an output register plus one skid entry, and counts retired
// A, C and illegal instructions with saturating counters.
module instr_decode_stage #(
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_decode_stage_if.slave  bus,
  input  logic                 flush,
  input  logic                 cnt_clr,
  output logic [CW-1:0]        cnt_a,
  output logic [CW-1:0]        cnt_c,
  output logic [CW-1:0]        cnt_ill
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  typedef struct packed {
    logic          is_c;
    logic [DW-1:0] value;
    logic          a;
    logic [5:0]    comp;
    logic [2:0]    dest;
    logic [2:0]    jump;
    logic          illegal;
  } dec_t;

  state_e        state_q, state_d;
  dec_t          out_q, out_d, skid_q, skid_d;
  dec_t          dec_c, out_sel;
  logic          in_ready_c, out_valid_c;
  logic          accept, pop;
  logic [CW-1:0] cnt_a_q, cnt_c_q, cnt_ill_q;

  // Field extraction of the incoming word; A-instructions carry only a value.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    dec_c = '0;
    if (bus.in_instr[DW-1]) begin
      dec_c.is_c    = 1'b1;
      dec_c.value   = bus.in_instr;
      dec_c.a       = bus.in_instr[DW-4];
      dec_c.comp    = bus.in_instr[DW-5 -: 6];
      dec_c.dest    = bus.in_instr[DW-11 -: 3];
      dec_c.jump    = bus.in_instr[DW-14 -: 3];
      dec_c.illegal = (bus.in_instr[DW-2 -: 2] != 2'b11);
    end else begin
      dec_c.value   = {1'b0, bus.in_instr[DW-2:0]};
    end
  end

  // FSM outputs: readiness and validity from occupancy; reset and flush block accepts.
  always_comb begin
    in_ready_c  = rst_n && !flush && (state_q != TWO);
    out_valid_c = (state_q != EMPTY);
  end

  assign accept = bus.in_valid & in_ready_c;
  assign pop    = out_valid_c & bus.out_ready;

  // FSM next state: occupancy tracking, flush overrides everything.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY:   if (accept) state_d = ONE;
        ONE:     if (accept && !pop) state_d = TWO;
                 else if (pop && !accept) state_d = EMPTY;
        TWO:     if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Data steering: new entries land in the output register when it frees up, else in skid.
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    unique case (state_q)
      EMPTY:   if (accept) out_d = dec_c;
      ONE:     if (accept && pop) out_d = dec_c;
               else if (accept) skid_d = dec_c;
      TWO:     if (pop) out_d = skid_q;
      default: ;
    endcase
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the two data entries are reset too; they are tiny and this keeps them never-X.
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

  // Retirement counters: clear wins, flush suppresses counting, saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q   <= '0;
      cnt_c_q   <= '0;
      cnt_ill_q <= '0;
    end else if (cnt_clr) begin
      cnt_a_q   <= '0;
      cnt_c_q   <= '0;
      cnt_ill_q <= '0;
    end else if (pop && !flush) begin
      if (!out_q.is_c && cnt_a_q != '1) cnt_a_q <= cnt_a_q + CW'(1);
      if (out_q.is_c && cnt_c_q != '1)  cnt_c_q <= cnt_c_q + CW'(1);
      if (out_q.illegal && cnt_ill_q != '1) cnt_ill_q <= cnt_ill_q + CW'(1);
    end
  end

  assign out_sel = out_valid_c ? out_q : '0;

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_type    = out_sel.is_c;
  assign bus.out_value   = out_sel.value;
  assign bus.out_a       = out_sel.a;
  assign bus.out_comp    = out_sel.comp;
  assign bus.out_dest    = out_sel.dest;
  assign bus.out_jump    = out_sel.jump;
  assign bus.out_illegal = out_sel.illegal;

  assign cnt_a   = cnt_a_q;
  assign cnt_c   = cnt_c_q;
  assign cnt_ill = cnt_ill_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_instr_decode_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_decode_stage_if #(.DW(16)) bus ();
  instr_decode_stage_if #(.DW(16)) bus2 ();

  logic        flush, cnt_clr, flush2, cnt_clr2;
  logic [15:0] cnt_a, cnt_c, cnt_ill;
  logic [1:0]  cnt2_a, cnt2_c, cnt2_ill;

  instr_decode_stage #(.DW(16), .CW(16)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .flush   (flush),
    .cnt_clr (cnt_clr),
    .cnt_a   (cnt_a),
    .cnt_c   (cnt_c),
    .cnt_ill (cnt_ill)
  );

  instr_decode_stage #(.DW(16), .CW(2)) u_small (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus2),
    .flush   (flush2),
    .cnt_clr (cnt_clr2),
    .cnt_a   (cnt2_a),
    .cnt_c   (cnt2_c),
    .cnt_ill (cnt2_ill)
  );

  // Reference model: a FIFO of up to two decoded entries plus plain integer counters.
  typedef struct packed {
    bit        is_c;
    bit [15:0] value;
    bit        a;
    bit [5:0]  comp;
    bit [2:0]  dest;
    bit [2:0]  jump;
    bit        ill;
  } exp_t;

  exp_t q[$];
  int   m_a, m_c, m_ill;
  int   n_chk, n_pass;
  localparam int SAT16 = 65535;

  function automatic exp_t ref_decode(bit [15:0] w);
    exp_t e;
    e = '0;
    if (w >= 16'h8000) begin
      e.is_c  = 1'b1;
      e.value = w;
      e.ill   = (((w >> 13) & 3) != 3);
      e.a     = 1'((w >> 12) & 1);
      e.comp  = 6'((w >> 6) & 63);
      e.dest  = 3'((w >> 3) & 7);
      e.jump  = 3'(w & 7);
    end else begin
      e.value = w % 16'h8000;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One clock: drive inputs after the falling edge, compare, advance the model, take the rising edge.
  task automatic cycle(input bit v, input bit [15:0] w, input bit ordy, input bit fl, input bit clr);
    bit   exp_rdy, exp_vld, acc, pop;
    exp_t head;
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = v;
    bus.in_instr = w;
    bus.out_ready = ordy;
    flush        = fl;
    cnt_clr      = clr;
    #1;
    exp_rdy = (q.size() < 2) && !fl;
    exp_vld = (q.size() > 0);
    head    = exp_vld ? q[0] : '0;
    check("in_ready",    32'(bus.in_ready),    32'(exp_rdy));
    check("out_valid",   32'(bus.out_valid),   32'(exp_vld));
    check("out_type",    32'(bus.out_type),    32'(head.is_c));
    check("out_value",   32'(bus.out_value),   32'(head.value));
    check("out_a",       32'(bus.out_a),       32'(head.a));
    check("out_comp",    32'(bus.out_comp),    32'(head.comp));
    check("out_dest",    32'(bus.out_dest),    32'(head.dest));
    check("out_jump",    32'(bus.out_jump),    32'(head.jump));
    check("out_illegal", 32'(bus.out_illegal), 32'(head.ill));
    check("cnt_a",       32'(cnt_a),           32'(m_a));
    check("cnt_c",       32'(cnt_c),           32'(m_c));
    check("cnt_ill",     32'(cnt_ill),         32'(m_ill));
    acc = v && exp_rdy;
    pop = exp_vld && ordy;
    if (fl) begin
      q.delete();
    end else begin
      if (clr) begin
        m_a = 0; m_c = 0; m_ill = 0;
      end else if (pop) begin
        if (head.is_c) m_c = (m_c < SAT16) ? m_c + 1 : m_c;
        else           m_a = (m_a < SAT16) ? m_a + 1 : m_a;
        if (head.ill)  m_ill = (m_ill < SAT16) ? m_ill + 1 : m_ill;
      end
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(ref_decode(w));
    end
    @(posedge clk);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    m_a = 0; m_c = 0; m_ill = 0;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_instr = '0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.in_instr = '0; bus2.out_ready = 0;
    flush = 0; cnt_clr = 0; flush2 = 0; cnt_clr2 = 0;

    // Reset state, before and after clock edges with reset held.
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_held", 32'(bus.in_ready), 32'd0);
    check("rst_out_value", 32'(bus.out_value), 32'd0);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    bus.in_valid = 0;

    // A-instruction retire.
    cycle(1, 16'h0005, 1, 0, 0);
    cycle(0, 16'h0000, 1, 0, 0);
    cycle(0, 16'h0000, 1, 0, 0);
    check("a_instr_cnt_a", 32'(cnt_a), 32'd1);

    // Well-formed C-instruction, then an illegal one.
    cycle(1, 16'hEC10, 0, 0, 0);
    cycle(1, 16'h8007, 1, 0, 0);
    cycle(0, 16'h0000, 1, 0, 0);
    cycle(0, 16'h0000, 1, 0, 0);
    #1;
    check("c_instr_cnt_c", 32'(cnt_c), 32'd2);
    check("c_instr_cnt_ill", 32'(cnt_ill), 32'd1);

    // Backpressure: third push held until the consumer drains.
    cycle(1, 16'h0001, 0, 0, 0);
    cycle(1, 16'h0002, 0, 0, 0);
    cycle(1, 16'h0003, 0, 0, 0);
    cycle(1, 16'h0003, 1, 0, 0);
    cycle(1, 16'h0003, 1, 0, 0);
    cycle(0, 16'h0000, 1, 0, 0);
    cycle(0, 16'h0000, 1, 0, 0);

    // Flush while full with a pending push and a ready consumer.
    cycle(1, 16'h0011, 0, 0, 0);
    cycle(1, 16'hE022, 0, 0, 0);
    cycle(1, 16'h0033, 1, 1, 0);
    cycle(0, 16'h0000, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      bit [15:0] w;
      bit fl, clr;
      w = 16'($urandom);
      if (w[15] && $urandom_range(3) != 0) w[14:13] = 2'b11;
      fl  = ($urandom_range(15) == 0);
      clr = !fl && ($urandom_range(63) == 0);
      cycle(1'($urandom), w, ($urandom_range(3) != 0), fl, clr);
    end

    // Asynchronous reset while full, between clock edges.
    cycle(1, 16'h8123, 0, 0, 0);
    cycle(1, 16'h0456, 0, 0, 0);
    cycle(1, 16'h0789, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("async_rst_out_value", 32'(bus.out_value), 32'd0);
    check("async_rst_cnt_a", 32'(cnt_a), 32'd0);
    check("async_rst_cnt_c", 32'(cnt_c), 32'd0);
    q.delete();
    m_a = 0; m_c = 0; m_ill = 0;
    @(posedge clk);
    // First edge after release accepts.
    cycle(1, 16'h1234, 0, 0, 0);
    cycle(0, 16'h0000, 1, 0, 0);
    cycle(0, 16'h0000, 1, 0, 0);

    // Saturation and clear on a 2-bit counter instance.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus2.in_valid = 1; bus2.in_instr = 16'(k + 1); bus2.out_ready = 1;
    end
    @(negedge clk);
    bus2.in_valid = 0;
    @(posedge clk);
    #1;
    check("sat_cnt_a", 32'(cnt2_a), 32'd3);
    check("sat_cnt_c", 32'(cnt2_c), 32'd0);
    @(negedge clk);
    bus2.in_valid = 1; bus2.in_instr = 16'h0007;
    @(negedge clk);
    bus2.in_valid = 0; cnt_clr2 = 1;
    check("clr_pop_valid", 32'(bus2.out_valid), 32'd1);
    @(posedge clk);
    #1;
    check("clr_cnt_a", 32'(cnt2_a), 32'd0);
    check("clr_out_valid", 32'(bus2.out_valid), 32'd0);
    cnt_clr2 = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameter DW, default 16, instruction width; SHALL be legal for DW >= 16.
REQ-002 Parameter CW, default 16, width of each statistics counter; SHALL be legal for CW >= 2.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  upstream instruction valid.
REQ-006 in_ready  out  1  stage can accept an instruction this cycle.
REQ-007 in_instr  in  DW  raw instruction word.
REQ-008 flush  in  1  synchronous pipeline flush.
REQ-009 out_valid  out  1  decoded instruction available.
REQ-010 out_ready  in  1  downstream accepts the decoded instruction.
REQ-011 out_type  out  1  0 = A-instruction, 1 = C-instruction.
REQ-012 out_value  out  DW  A: instruction with MSB cleared; C: raw instruction.
REQ-013 out_a / out_comp / out_dest / out_jump  out  1 / 6 / 3 / 3  C-instruction fields.
REQ-014 out_illegal  out  1  C-instruction with malformed prefix.
REQ-015 cnt_clr  in  1  synchronous clear of all counters.
REQ-016 cnt_a / cnt_c / cnt_ill  out  CW each  retired A, C and illegal instruction counts.

Function
REQ-017 Decode on input: type = instr[DW-1]; a = instr[DW-4]; comp = instr[DW-5:DW-10] (c1 is the MSB); dest = instr[DW-11:DW-13]; jump = instr[DW-14:DW-16]; bits below DW-16 SHALL be ignored for the C fields.
REQ-018 For an A-instruction, a, comp, dest, jump and illegal SHALL all be 0.
REQ-019 illegal SHALL be 1 iff type = 1 and instr[DW-2:DW-3] != 2'b11.
REQ-020 The stage SHALL store decoded results in an output register plus a one-entry skid register, with states EMPTY, ONE and TWO.
REQ-021 Accept = in_valid & in_ready. Pop = out_valid & out_ready.
REQ-022 in_ready SHALL be 1 in EMPTY and ONE, and 0 in TWO, while flush = 1, and while rst_n = 0.
REQ-023 out_valid SHALL be 1 in ONE and TWO, and 0 in EMPTY.
REQ-024 Transitions from EMPTY: accept -> ONE; no accept -> stay.
REQ-025 Transitions from ONE:
  - accept & !pop -> TWO, new entry into skid;
  - accept & pop -> ONE, new entry into output register;
  - pop & !accept -> EMPTY;
  - otherwise stay.
REQ-026 Transitions from TWO: pop -> ONE, skid moves into output register; otherwise stay.
REQ-027 Latency SHALL be 1 cycle: an instruction accepted at edge N SHALL appear at the outputs after edge N when the stage was EMPTY, or when in ONE with a pop in the same cycle.
REQ-028 Order SHALL be preserved; no instruction SHALL be dropped or duplicated except by flush or reset.
REQ-029 While out_valid = 0, all out_* data outputs SHALL be 0.
REQ-030 Flush has highest priority: the next state SHALL be EMPTY, both entries SHALL be discarded, no accept SHALL occur, and no counter SHALL increment that cycle.
REQ-031 On each pop (and not flush), cnt_a or cnt_c SHALL increment by 1 according to out_type, and cnt_ill SHALL also increment when out_illegal = 1.
REQ-032 Counters SHALL saturate at 2^CW-1.
REQ-033 cnt_clr SHALL zero all counters and SHALL take priority over a simultaneous increment.

Reset
REQ-034 While rst_n = 0, and immediately on its assertion regardless of clk, the stage SHALL be in EMPTY, with out_valid = 0, in_ready = 0, all out_* = 0 and all counters = 0.
REQ-035 Reset asserted mid-operation SHALL discard all stored entries.
REQ-036 The first accept after reset SHALL be possible on the first rising edge with rst_n = 1.

Verification
REQ-037 in_instr = 16'h0005 accepted, out_ready = 1 -> next cycle out_valid = 1, out_type = 0, out_value = 16'h0005, all fields 0; cnt_a = 1 after the pop.
REQ-038 in_instr = 16'hEC10 -> out_type = 1, out_a = 0, out_comp = 6'b110000, out_dest = 3'b010, out_jump = 3'b000, out_illegal = 0, out_value = 16'hEC10.
REQ-039 in_instr = 16'h8007 -> out_illegal = 1, out_jump = 3'b111; after the pop, cnt_c = 1 and cnt_ill = 1.
REQ-040 Backpressure: out_ready = 0, push 16'h0001, 16'h0002, 16'h0003 back-to-back -> the first two are accepted, in_ready = 0 with 16'h0003 held; then out_ready = 1 -> pops deliver 1, 2, 3 in order, one per cycle.
REQ-041 In TWO, assert flush for 1 cycle with in_valid = 1 -> in_ready = 0 that cycle, out_valid = 0 next cycle, counters unchanged.
REQ-042 CW = 2: pop 5 A-instructions -> cnt_a = 3; then cnt_clr with a simultaneous pop -> cnt_a = 0.
REQ-043 Assert rst_n = 0 in state TWO between clock edges -> out_valid = 0 and counters = 0 immediately, with no edge required.
